instr_fetch_stage: RTL and testbench
====================================

Name: instr_fetch_stage

Overview:
Instruction-fetch stage of the 5-stage pipelined MIPS core. Holds the program counter and drives the word address into the instruction ROM. Registers the ROM's combinational read data into the IF/ID pipeline register. Applies stall, flush and redirect requests from the hazard unit, branch/jump logic and exception/interrupt logic.

Parameters:
RESET_VEC, 32'h8000_0000, PC value after reset.
IRQ_VEC, 32'h8000_0004, interrupt handler entry.
EXC_VEC, 32'h8000_0008, undefined-instruction/exception handler entry.
NOP_INSTR, 32'h0000_0000, bubble inserted into IF/ID on flush or reset.

Ports:
clk  in  1  core clock, all state on rising edge
reset  in  1  asynchronous, active-low reset
rom_addr  out  32  byte address to instruction ROM; equals pc
rom_data  in  32  combinational instruction word from ROM
stall_if  in  1  load-use stall from hazard unit: hold PC and IF/ID
flush_if  in  1  kill instruction currently in IF (write bubble to IF/ID)
branch_taken  in  1  conditional branch resolved taken
branch_target  in  32  branch destination
jump  in  1  J/JAL in ID
jump_target  in  32  J/JAL destination (bit 31 already preserved by ID)
jr  in  1  JR/JALR in ID
jr_target  in  32  register destination
irq  in  1  external interrupt request (level)
exception  in  1  undefined instruction detected downstream
pc  out  32  current fetch PC
if_id_instr  out  32  IF/ID instruction
if_id_pc_plus4  out  32  IF/ID PC+4 (link value / branch base)
if_id_valid  out  1  1 = IF/ID holds a real instruction, 0 = bubble
epc  out  32  return address captured on interrupt/exception entry

Behaviour:
- Reset (reset=0, async): pc=RESET_VEC, if_id_instr=NOP_INSTR, if_id_pc_plus4=0, if_id_valid=0, epc=0. Outputs stay at these values while reset is low. First fetch happens on the first rising edge after release.
- rom_addr = pc, combinational. The ROM ignores bits [1:0]; zero-cycle read latency.
- pc_plus4 = {pc[31], pc[30:0]+31'd4}. The supervisor bit (bit 31) never changes on sequential fetch; bits [30:0] wrap modulo 2^31.
- irq_take = irq & ~pc[31]. Interrupts are masked in supervisor mode.
- Next-PC priority, highest first:
  1. exception -> EXC_VEC
  2. irq_take -> IRQ_VEC
  3. jr -> {jr_target[31:2],2'b00}; a user-mode jr may not set bit 31, so use {pc[31]&jr_target[31], jr_target[30:2], 2'b00}
  4. jump -> jump_target
  5. branch_taken -> branch_target
  6. stall_if -> pc (hold)
  7. otherwise -> pc_plus4
- Redirect = any of 1-5. A redirect overrides stall_if.
- IF/ID register, per rising edge:
  - redirect or flush_if -> if_id_instr=NOP_INSTR, if_id_valid=0, if_id_pc_plus4=pc_plus4.
  - else stall_if -> all IF/ID fields hold.
  - else -> if_id_instr=rom_data, if_id_pc_plus4=pc_plus4, if_id_valid=1.
- epc: on an edge where exception or irq_take wins, epc = pc (address of the killed fetch, resumed after ERET). Otherwise epc holds.
- Fetch latency: the instruction at PC N appears on if_id_instr one cycle after pc=N. The redirect penalty is one bubble.
- Simultaneous events:
  - Exception and irq in the same cycle: the exception wins and the interrupt stays pending (irq is level).
  - flush_if together with stall_if: flush wins in IF/ID and the PC holds.
- Reset asserted mid-operation returns all state to the reset values immediately, regardless of clk.

Test Plan:
1. Release reset, no control inputs; ROM holds words 0x11,0x22,0x33 at 0x8000_0000/4/8. Required: pc steps 0x8000_0000 -> 0x8000_0004 -> 0x8000_0008; if_id_instr=0x11,0x22 one cycle behind; if_id_valid rises on the first edge.
2. stall_if=1 for 2 cycles at pc=0x8000_0008. Required: pc and IF/ID (0x22, pc_plus4=0x8000_0008) hold for both cycles. Fetch resumes with 0x33.
3. branch_taken=1, branch_target=0x8000_0040, with stall_if=1 in the same cycle. Required: next pc=0x8000_0040, IF/ID is a bubble (valid=0, instr=0).
4. pc=0x0000_0100 (user mode), irq=1. Required: next pc=0x8000_0004, epc=0x0000_0100, bubble in IF/ID. With pc=0x8000_0100, irq=1: no redirect, pc -> 0x8000_0104.
5. exception=1 and irq=1 and jump=1 in the same cycle at pc=0x0000_0200. Required: pc=0x8000_0008, epc=0x0000_0200.
6. pc=0x7FFF_FFFC (user mode). Required: next pc=0x0000_0000, bit 31 stays 0. A user-mode jr_target=0x8000_0013 gives pc=0x0000_0010. Assert reset mid-run: pc=0x8000_0000 asynchronously and if_id_valid=0.

Source files
------------

// File: rtl/instr_fetch_stage_if.sv
// Signal bundle between the fetch stage and its environment: instruction ROM,
// hazard/branch/exception control inputs and the IF/ID pipeline outputs.
interface instr_fetch_stage_if;
    logic [31:0] rom_addr;
    logic [31:0] rom_data;
    logic        stall_if;
    logic        flush_if;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic        jr;
    logic [31:0] jr_target;
    logic        irq;
    logic        exception;
    logic [31:0] pc;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc_plus4;
    logic        if_id_valid;
    logic [31:0] epc;

    modport master (
        output rom_addr, pc, if_id_instr, if_id_pc_plus4, if_id_valid, epc,
        input  rom_data, stall_if, flush_if, branch_taken, branch_target,
               jump, jump_target, jr, jr_target, irq, exception
    );

    modport slave (
        input  rom_addr, pc, if_id_instr, if_id_pc_plus4, if_id_valid, epc,
        output rom_data, stall_if, flush_if, branch_taken, branch_target,
               jump, jump_target, jr, jr_target, irq, exception
    );
endinterface

// File: rtl/instr_fetch_stage.sv
// MIPS instruction-fetch stage: program counter, next-PC selection with
// exception/interrupt/jump/branch priority, and the IF/ID pipeline register.
module instr_fetch_stage #(
    parameter logic [31:0] RESET_VEC = 32'h8000_0000,
    parameter logic [31:0] IRQ_VEC   = 32'h8000_0004,
    parameter logic [31:0] EXC_VEC   = 32'h8000_0008,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic                clk,
    input  logic                reset,
    instr_fetch_stage_if.master bus
);

    logic [31:0] pc_reg, pc_next;
    logic [31:0] instr_reg, instr_next;
    logic [31:0] pp4_reg, pp4_next;
    logic        valid_reg, valid_next;
    logic [31:0] epc_reg, epc_next;
    logic [31:0] pc_plus4;
    logic        irq_take;
    logic        trap;
    logic        redirect;
    logic        unused_jr_bits;

    // Bit 31 is the supervisor bit; sequential fetch never crosses it.
    assign pc_plus4 = {pc_reg[31], pc_reg[30:0] + 31'd4};
    assign irq_take = bus.irq & ~pc_reg[31];
    assign trap     = bus.exception | irq_take;
    assign redirect = trap | bus.jr | bus.jump | bus.branch_taken;

    assign unused_jr_bits = ^bus.jr_target[1:0];

    always_comb begin
        pc_next = pc_plus4;
        if (bus.exception) begin
            pc_next = EXC_VEC;
        end else if (irq_take) begin
            pc_next = IRQ_VEC;
        end else if (bus.jr) begin
            // A user-mode register jump cannot promote itself to supervisor.
            pc_next = {pc_reg[31] & bus.jr_target[31], bus.jr_target[30:2], 2'b00};
        end else if (bus.jump) begin
            pc_next = bus.jump_target;
        end else if (bus.branch_taken) begin
            pc_next = bus.branch_target;
        end else if (bus.stall_if) begin
            pc_next = pc_reg;
        end
    end

    always_comb begin
        instr_next = instr_reg;
        pp4_next   = pp4_reg;
        valid_next = valid_reg;
        epc_next   = epc_reg;
        if (redirect || bus.flush_if) begin
            instr_next = NOP_INSTR;
            pp4_next   = pc_plus4;
            valid_next = 1'b0;
        end else if (!bus.stall_if) begin
            instr_next = bus.rom_data;
            pp4_next   = pc_plus4;
            valid_next = 1'b1;
        end
        if (trap) begin
            epc_next = pc_reg;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_reg    <= RESET_VEC;
            instr_reg <= NOP_INSTR;
            pp4_reg   <= 32'h0;
            valid_reg <= 1'b0;
            epc_reg   <= 32'h0;
        end else begin
            pc_reg    <= pc_next;
            instr_reg <= instr_next;
            pp4_reg   <= pp4_next;
            valid_reg <= valid_next;
            epc_reg   <= epc_next;
        end
    end

    assign bus.rom_addr       = pc_reg;
    assign bus.pc             = pc_reg;
    assign bus.if_id_instr    = instr_reg;
    assign bus.if_id_pc_plus4 = pp4_reg;
    assign bus.if_id_valid    = valid_reg;
    assign bus.epc            = epc_reg;

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Bench for instr_fetch_stage: directed vector table from reset, async reset
// sequence, then randomized control traffic against a reference model.
module tb_instr_fetch_stage;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    instr_fetch_stage_if bus ();

    instr_fetch_stage dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [31:0] addr);
        logic [31:0] a;
        a = {addr[31:2], 2'b00};
        case (a)
            32'h8000_0000: return 32'h0000_0011;
            32'h8000_0004: return 32'h0000_0022;
            32'h8000_0008: return 32'h0000_0033;
            32'h8000_0100: return 32'h0000_0044;
            32'h7FFF_FFFC: return 32'h0000_0055;
            32'h0000_0014: return 32'h0000_0066;
            default:       return a ^ 32'hC0DE_0000;
        endcase
    endfunction

    assign bus.rom_data = rom_word(bus.rom_addr);

    // ctrl bits: [6]exception [5]irq [4]jr [3]jump [2]branch [1]flush [0]stall
    typedef struct {
        logic [6:0]  ctrl;
        logic [31:0] tgt;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
        logic [31:0] e_pp4;
        logic        e_valid;
        logic [31:0] e_epc;
    } vec_t;

    vec_t vecs[18];

    // Reference model state
    logic [31:0] m_pc, m_instr, m_pp4, m_epc;
    logic        m_valid;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%08h required=%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [6:0] ctrl, input logic [31:0] bt,
                         input logic [31:0] jt, input logic [31:0] rt);
        bus.exception     = ctrl[6];
        bus.irq           = ctrl[5];
        bus.jr            = ctrl[4];
        bus.jump          = ctrl[3];
        bus.branch_taken  = ctrl[2];
        bus.flush_if      = ctrl[1];
        bus.stall_if      = ctrl[0];
        bus.branch_target = bt;
        bus.jump_target   = jt;
        bus.jr_target     = rt;
    endtask

    task automatic check_all(input string tag, input logic [31:0] pc, input logic [31:0] instr,
                             input logic [31:0] pp4, input logic valid, input logic [31:0] epc);
        chk({tag, ".pc"}, bus.pc, pc);
        chk({tag, ".rom_addr"}, bus.rom_addr, pc);
        chk({tag, ".instr"}, bus.if_id_instr, instr);
        chk({tag, ".pc_plus4"}, bus.if_id_pc_plus4, pp4);
        chk({tag, ".valid"}, {31'h0, bus.if_id_valid}, {31'h0, valid});
        chk({tag, ".epc"}, bus.epc, epc);
    endtask

    task automatic model_reset();
        m_pc = 32'h8000_0000; m_instr = 32'h0; m_pp4 = 32'h0; m_valid = 1'b0; m_epc = 32'h0;
    endtask

    // Advance the model by one rising edge using the currently driven inputs.
    task automatic model_step();
        logic        take_irq, redir;
        logic [31:0] seq, npc;
        take_irq = bus.irq && (m_pc < 32'h8000_0000);
        redir    = bus.exception || take_irq || bus.jr || bus.jump || bus.branch_taken;
        seq      = (m_pc & 32'h8000_0000) | ((m_pc + 32'd4) & 32'h7FFF_FFFF);
        if (bus.exception)         npc = 32'h8000_0008;
        else if (take_irq)         npc = 32'h8000_0004;
        else if (bus.jr)           npc = (bus.jr_target & 32'h7FFF_FFFC) |
                                         (m_pc & bus.jr_target & 32'h8000_0000);
        else if (bus.jump)         npc = bus.jump_target;
        else if (bus.branch_taken) npc = bus.branch_target;
        else if (bus.stall_if)     npc = m_pc;
        else                       npc = seq;
        if (redir || bus.flush_if) begin
            m_instr = 32'h0; m_valid = 1'b0; m_pp4 = seq;
        end else if (!bus.stall_if) begin
            m_instr = rom_word(m_pc); m_valid = 1'b1; m_pp4 = seq;
        end
        if (bus.exception || take_irq) m_epc = m_pc;
        m_pc = npc;
    endtask

    task automatic set_vec(input int i, input logic [6:0] ctrl, input logic [31:0] tgt,
                           input logic [31:0] pc, input logic [31:0] instr,
                           input logic [31:0] pp4, input logic valid, input logic [31:0] epc);
        vecs[i].ctrl = ctrl; vecs[i].tgt = tgt; vecs[i].e_pc = pc; vecs[i].e_instr = instr;
        vecs[i].e_pp4 = pp4; vecs[i].e_valid = valid; vecs[i].e_epc = epc;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        set_vec(0,  7'h00, 32'h0,         32'h8000_0004, 32'h11, 32'h8000_0004, 1, 32'h0);
        set_vec(1,  7'h00, 32'h0,         32'h8000_0008, 32'h22, 32'h8000_0008, 1, 32'h0);
        set_vec(2,  7'h01, 32'h0,         32'h8000_0008, 32'h22, 32'h8000_0008, 1, 32'h0);
        set_vec(3,  7'h01, 32'h0,         32'h8000_0008, 32'h22, 32'h8000_0008, 1, 32'h0);
        set_vec(4,  7'h00, 32'h0,         32'h8000_000C, 32'h33, 32'h8000_000C, 1, 32'h0);
        set_vec(5,  7'h05, 32'h8000_0040, 32'h8000_0040, 32'h0,  32'h8000_0010, 0, 32'h0);
        set_vec(6,  7'h10, 32'h0000_0100, 32'h0000_0100, 32'h0,  32'h8000_0044, 0, 32'h0);
        set_vec(7,  7'h20, 32'h0,         32'h8000_0004, 32'h0,  32'h0000_0104, 0, 32'h100);
        set_vec(8,  7'h10, 32'h0000_0200, 32'h0000_0200, 32'h0,  32'h8000_0008, 0, 32'h100);
        set_vec(9,  7'h68, 32'h1234_5678, 32'h8000_0008, 32'h0,  32'h0000_0204, 0, 32'h200);
        set_vec(10, 7'h10, 32'h8000_0100, 32'h8000_0100, 32'h0,  32'h8000_000C, 0, 32'h200);
        set_vec(11, 7'h20, 32'h0,         32'h8000_0104, 32'h44, 32'h8000_0104, 1, 32'h200);
        set_vec(12, 7'h08, 32'h7FFF_FFFC, 32'h7FFF_FFFC, 32'h0,  32'h8000_0108, 0, 32'h200);
        set_vec(13, 7'h00, 32'h0,         32'h0000_0000, 32'h55, 32'h0000_0000, 1, 32'h200);
        set_vec(14, 7'h10, 32'h8000_0013, 32'h0000_0010, 32'h0,  32'h0000_0004, 0, 32'h200);
        set_vec(15, 7'h03, 32'h0,         32'h0000_0010, 32'h0,  32'h0000_0014, 0, 32'h200);
        set_vec(16, 7'h02, 32'h0,         32'h0000_0014, 32'h0,  32'h0000_0014, 0, 32'h200);
        set_vec(17, 7'h00, 32'h0,         32'h0000_0018, 32'h66, 32'h0000_0018, 1, 32'h200);

        // Reset state, including clock edges seen while reset is low
        reset = 1'b0;
        drive(7'h00, 32'h0, 32'h0, 32'h0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_all("reset", 32'h8000_0000, 32'h0, 32'h0, 1'b0, 32'h0);
        reset = 1'b1;

        for (int i = 0; i < 18; i++) begin
            drive(vecs[i].ctrl, vecs[i].tgt, vecs[i].tgt, vecs[i].tgt);
            @(posedge clk); #1;
            $display("vec %0d ctrl=%02h pc=%08h instr=%08h valid=%0b epc=%08h",
                     i, vecs[i].ctrl, bus.pc, bus.if_id_instr, bus.if_id_valid, bus.epc);
            check_all($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_instr,
                      vecs[i].e_pp4, vecs[i].e_valid, vecs[i].e_epc);
        end

        // Asynchronous reset mid-cycle, away from any clock edge
        drive(7'h00, 32'h0, 32'h0, 32'h0);
        #3 reset = 1'b0;
        #1;
        $display("async reset pc=%08h valid=%0b", bus.pc, bus.if_id_valid);
        check_all("async_rst", 32'h8000_0000, 32'h0, 32'h0, 1'b0, 32'h0);
        @(posedge clk); #1;
        check_all("rst_hold", 32'h8000_0000, 32'h0, 32'h0, 1'b0, 32'h0);
        #2 reset = 1'b1;
        model_reset();

        // Randomized control traffic against the reference model
        for (int n = 0; n < 400; n++) begin
            logic [6:0] c;
            c[6] = ($urandom_range(0, 99) < 5);
            c[5] = ($urandom_range(0, 99) < 15);
            c[4] = ($urandom_range(0, 99) < 8);
            c[3] = ($urandom_range(0, 99) < 8);
            c[2] = ($urandom_range(0, 99) < 10);
            c[1] = ($urandom_range(0, 99) < 8);
            c[0] = ($urandom_range(0, 99) < 20);
            drive(c, $urandom, $urandom, $urandom);
            model_step();
            @(posedge clk); #1;
            $display("rnd %0d ctrl=%02h pc=%08h instr=%08h valid=%0b epc=%08h",
                     n, c, bus.pc, bus.if_id_instr, bus.if_id_valid, bus.epc);
            check_all($sformatf("rnd%0d", n), m_pc, m_instr, m_pp4, m_valid, m_epc);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
